axi_xbar_1x2: RTL
=================

Name: axi_xbar_1x2

Overview:
- Single-master to two-slave AXI4 address router placed directly upstream of the CLINT slave.
- Upstream port (up_*) connects to the core's memory-side AXI master.
- Downstream port 0 (clint_*) feeds the CLINT timer slave; port 1 (soc_*) feeds the SoC/memory fabric.
- Decodes every AR/AW address, forwards the transaction to one slave, and steers its R/B responses back. Read and write paths are independent; each allows one outstanding transaction.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, ID width
- CLINT_BASE, 32'h0200_0000, first CLINT byte address
- CLINT_SIZE, 32'h0001_0000, CLINT window size in bytes (power of two)

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset
- up_ar_valid/ready/addr/id/len/size/burst  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  upstream read address
- up_r_valid/ready/data/resp/last/id  out/in/out/out/out/out  1/1/DATA_W/2/1/ID_W  upstream read data
- up_aw_valid/ready/addr/id/len/size/burst  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/2  upstream write address
- up_w_valid/ready/data/strb/last  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  upstream write data
- up_b_valid/ready/resp/id  out/in/out/out  1/1/2/ID_W  upstream write response
- clint_{ar,r,aw,w,b}_*  mirror of up_* with directions reversed  slave 0
- soc_{ar,r,aw,w,b}_*  mirror of up_* with directions reversed  slave 1

Behaviour:
- Reset: areset_n is synchronous, active-low; clock is aclk.
  - While areset_n=0, both FSMs go to IDLE.
  - All downstream valids, up_r_valid and up_b_valid are 0; up_w_ready is 0.
- Decode: hit = (addr >= CLINT_BASE) && (addr < CLINT_BASE+CLINT_SIZE). A hit selects CLINT; everything else selects SoC. There is no decode-error region.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE:
    - Selected slave: ar_valid = up_ar_valid; ar addr/id/len/size/burst are passed through combinationally.
    - Other slave: ar_valid = 0.
    - up_ar_ready = selected slave's ar_ready.
    - On the up_ar handshake, latch rsel and go to R_DATA. Zero added latency.
  - R_DATA:
    - up_ar_ready = 0.
    - up_r_* is muxed from rsel's slave; only that slave gets r_ready = up_r_ready.
    - On up_r_valid & up_r_ready & up_r_last, return to R_IDLE. A new AR is accepted no earlier than the next cycle.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AW is routed like AR. up_w_ready = 0, so W cannot be accepted before AW.
  - W_DATA: W is forwarded to wsel's slave; on the upstream W handshake with w_last, go to W_RESP.
  - W_RESP: B is forwarded from wsel's slave; on the up_b handshake, return to W_IDLE.
- Read and write FSMs run concurrently; simultaneous AR and AW to different or same slaves are both legal.
- Unselected slave: valid and ready are held at 0; data fields are don't-care but driven 0.
- rsel/wsel are stable for the whole transaction, even if the up address changes after the handshake.
- No response buffering: slave-side backpressure propagates unchanged.
- Reset mid-burst: the transaction is abandoned. The FSM is in IDLE on the first cycle after reset deasserts, and no stray valid is emitted.

Optional Feature:
- Macro: XBAR_CLINT_WR_ERR_EN.
- Defined:
  - clint_aw_valid and clint_w_valid are tied to 0.
  - A write hitting the CLINT window is terminated locally: up_aw_ready=1 in W_IDLE.
  - In W_DATA, up_w_ready=1 and beats are discarded until w_last.
  - In W_RESP, up_b_valid=1, up_b_resp=2'b10 (SLVERR), up_b_id = latched AW id.
- Not defined: CLINT-window writes are forwarded to the clint_* port like any other write.

Test Plan:
- AR addr 0x0200_0000, len 0 -> clint_ar_valid=1, soc_ar_valid=0; CLINT R data 0x0000_1234 returned on up_r with last=1; FSM back to R_IDLE the cycle after the handshake.
- AR addr 0x8000_0000, len 3 -> routed to soc; 4 beats pass through with up_r_ready toggled 1,0,1; only the 4th beat has last=1; no beat is dropped or duplicated.
- AR 0x0200_0004 and AW 0x8000_0010 issued in the same cycle -> both accepted concurrently; B resp 2'b00 from soc; CLINT read completes independently.
- W presented before AW (AW delayed 3 cycles) -> up_w_ready=0 until the AW handshake, then the data reaches soc intact.
- With XBAR_CLINT_WR_ERR_EN: AW 0x0200_0000, id 4'h5, 1 beat -> clint_aw_valid stays 0; up_b resp=2'b10, id=4'h5. Without the macro, the same AW reaches clint_aw.
- areset_n pulled low for 1 cycle during beat 2 of a 4-beat soc read -> all valids 0 in the next cycle; a fresh AR to 0x0200_0000 then completes normally.

Source files
------------

// File: rtl/axi_xbar_1x2.sv
// One-master to two-slave AXI4 router: CLINT window -> clint_*, everything else -> soc_*.
// Optional XBAR_CLINT_WR_ERR_EN: CLINT-window writes terminate locally with SLVERR.
module axi_xbar_1x2 #(
   parameter int unsigned     ADDR_W     = 32,
   parameter int unsigned     DATA_W     = 32,
   parameter int unsigned     ID_W       = 4,
   parameter logic [ADDR_W-1:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [ADDR_W-1:0] CLINT_SIZE = 32'h0001_0000
) (
   input  logic                aclk,
   input  logic                areset_n,
   // upstream
   input  logic                up_ar_valid,
   output logic                up_ar_ready,
   input  logic [ADDR_W-1:0]   up_ar_addr,
   input  logic [ID_W-1:0]     up_ar_id,
   input  logic [7:0]          up_ar_len,
   input  logic [2:0]          up_ar_size,
   input  logic [1:0]          up_ar_burst,
   output logic                up_r_valid,
   input  logic                up_r_ready,
   output logic [DATA_W-1:0]   up_r_data,
   output logic [1:0]          up_r_resp,
   output logic                up_r_last,
   output logic [ID_W-1:0]     up_r_id,
   input  logic                up_aw_valid,
   output logic                up_aw_ready,
   input  logic [ADDR_W-1:0]   up_aw_addr,
   input  logic [ID_W-1:0]     up_aw_id,
   input  logic [7:0]          up_aw_len,
   input  logic [2:0]          up_aw_size,
   input  logic [1:0]          up_aw_burst,
   input  logic                up_w_valid,
   output logic                up_w_ready,
   input  logic [DATA_W-1:0]   up_w_data,
   input  logic [DATA_W/8-1:0] up_w_strb,
   input  logic                up_w_last,
   output logic                up_b_valid,
   input  logic                up_b_ready,
   output logic [1:0]          up_b_resp,
   output logic [ID_W-1:0]     up_b_id,
   // slave 0: CLINT
   output logic                clint_ar_valid,
   input  logic                clint_ar_ready,
   output logic [ADDR_W-1:0]   clint_ar_addr,
   output logic [ID_W-1:0]     clint_ar_id,
   output logic [7:0]          clint_ar_len,
   output logic [2:0]          clint_ar_size,
   output logic [1:0]          clint_ar_burst,
   input  logic                clint_r_valid,
   output logic                clint_r_ready,
   input  logic [DATA_W-1:0]   clint_r_data,
   input  logic [1:0]          clint_r_resp,
   input  logic                clint_r_last,
   input  logic [ID_W-1:0]     clint_r_id,
   output logic                clint_aw_valid,
   input  logic                clint_aw_ready,
   output logic [ADDR_W-1:0]   clint_aw_addr,
   output logic [ID_W-1:0]     clint_aw_id,
   output logic [7:0]          clint_aw_len,
   output logic [2:0]          clint_aw_size,
   output logic [1:0]          clint_aw_burst,
   output logic                clint_w_valid,
   input  logic                clint_w_ready,
   output logic [DATA_W-1:0]   clint_w_data,
   output logic [DATA_W/8-1:0] clint_w_strb,
   output logic                clint_w_last,
   input  logic                clint_b_valid,
   output logic                clint_b_ready,
   input  logic [1:0]          clint_b_resp,
   input  logic [ID_W-1:0]     clint_b_id,
   // slave 1: SoC fabric
   output logic                soc_ar_valid,
   input  logic                soc_ar_ready,
   output logic [ADDR_W-1:0]   soc_ar_addr,
   output logic [ID_W-1:0]     soc_ar_id,
   output logic [7:0]          soc_ar_len,
   output logic [2:0]          soc_ar_size,
   output logic [1:0]          soc_ar_burst,
   input  logic                soc_r_valid,
   output logic                soc_r_ready,
   input  logic [DATA_W-1:0]   soc_r_data,
   input  logic [1:0]          soc_r_resp,
   input  logic                soc_r_last,
   input  logic [ID_W-1:0]     soc_r_id,
   output logic                soc_aw_valid,
   input  logic                soc_aw_ready,
   output logic [ADDR_W-1:0]   soc_aw_addr,
   output logic [ID_W-1:0]     soc_aw_id,
   output logic [7:0]          soc_aw_len,
   output logic [2:0]          soc_aw_size,
   output logic [1:0]          soc_aw_burst,
   output logic                soc_w_valid,
   input  logic                soc_w_ready,
   output logic [DATA_W-1:0]   soc_w_data,
   output logic [DATA_W/8-1:0] soc_w_strb,
   output logic                soc_w_last,
   input  logic                soc_b_valid,
   output logic                soc_b_ready,
   input  logic [1:0]          soc_b_resp,
   input  logic [ID_W-1:0]     soc_b_id
);

   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

   // One extra bit so a window ending at the top of the address space does not wrap
   localparam logic [ADDR_W:0] CLINT_END = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};

   r_state_e r_state_q, r_state_d;
   w_state_e w_state_q, w_state_d;
   logic     rsel_q, rsel_d;   // 1 = CLINT
   logic     wsel_q, wsel_d;
   logic     ar_hit, aw_hit;

   assign ar_hit = ({1'b0, up_ar_addr} >= {1'b0, CLINT_BASE}) && ({1'b0, up_ar_addr} < CLINT_END);
   assign aw_hit = ({1'b0, up_aw_addr} >= {1'b0, CLINT_BASE}) && ({1'b0, up_aw_addr} < CLINT_END);

`ifdef XBAR_CLINT_WR_ERR_EN
   logic [ID_W-1:0] wid_q, wid_d;
   logic            unused_clint_wr;
   assign unused_clint_wr = ^{clint_aw_ready, clint_w_ready, clint_b_valid, clint_b_resp, clint_b_id};
`endif

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         rsel_q    <= 1'b0;
         wsel_q    <= 1'b0;
`ifdef XBAR_CLINT_WR_ERR_EN
         wid_q     <= '0;
`endif
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rsel_q    <= rsel_d;
         wsel_q    <= wsel_d;
`ifdef XBAR_CLINT_WR_ERR_EN
         wid_q     <= wid_d;
`endif
      end
   end

   // Read path: route AR by address, then steer R from the latched slave
   always_comb begin
      r_state_d      = r_state_q;
      rsel_d         = rsel_q;
      up_ar_ready    = 1'b0;
      clint_ar_valid = 1'b0;
      clint_ar_addr  = '0;
      clint_ar_id    = '0;
      clint_ar_len   = '0;
      clint_ar_size  = '0;
      clint_ar_burst = '0;
      soc_ar_valid   = 1'b0;
      soc_ar_addr    = '0;
      soc_ar_id      = '0;
      soc_ar_len     = '0;
      soc_ar_size    = '0;
      soc_ar_burst   = '0;
      up_r_valid     = 1'b0;
      up_r_data      = '0;
      up_r_resp      = '0;
      up_r_last      = 1'b0;
      up_r_id        = '0;
      clint_r_ready  = 1'b0;
      soc_r_ready    = 1'b0;
      if (areset_n) begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_hit) begin
                  clint_ar_valid = up_ar_valid;
                  clint_ar_addr  = up_ar_addr;
                  clint_ar_id    = up_ar_id;
                  clint_ar_len   = up_ar_len;
                  clint_ar_size  = up_ar_size;
                  clint_ar_burst = up_ar_burst;
                  up_ar_ready    = clint_ar_ready;
               end else begin
                  soc_ar_valid   = up_ar_valid;
                  soc_ar_addr    = up_ar_addr;
                  soc_ar_id      = up_ar_id;
                  soc_ar_len     = up_ar_len;
                  soc_ar_size    = up_ar_size;
                  soc_ar_burst   = up_ar_burst;
                  up_ar_ready    = soc_ar_ready;
               end
               if (up_ar_valid && up_ar_ready) begin
                  rsel_d    = ar_hit;
                  r_state_d = R_DATA;
               end
            end
            R_DATA: begin
               if (rsel_q) begin
                  up_r_valid    = clint_r_valid;
                  up_r_data     = clint_r_data;
                  up_r_resp     = clint_r_resp;
                  up_r_last     = clint_r_last;
                  up_r_id       = clint_r_id;
                  clint_r_ready = up_r_ready;
               end else begin
                  up_r_valid    = soc_r_valid;
                  up_r_data     = soc_r_data;
                  up_r_resp     = soc_r_resp;
                  up_r_last     = soc_r_last;
                  up_r_id       = soc_r_id;
                  soc_r_ready   = up_r_ready;
               end
               if (up_r_valid && up_r_ready && up_r_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
         endcase
      end
   end

   // Write path: AW, then W beats, then B, all bound to the slave chosen at AW
   always_comb begin
      w_state_d      = w_state_q;
      wsel_d         = wsel_q;
`ifdef XBAR_CLINT_WR_ERR_EN
      wid_d          = wid_q;
`endif
      up_aw_ready    = 1'b0;
      clint_aw_valid = 1'b0;
      clint_aw_addr  = '0;
      clint_aw_id    = '0;
      clint_aw_len   = '0;
      clint_aw_size  = '0;
      clint_aw_burst = '0;
      soc_aw_valid   = 1'b0;
      soc_aw_addr    = '0;
      soc_aw_id      = '0;
      soc_aw_len     = '0;
      soc_aw_size    = '0;
      soc_aw_burst   = '0;
      up_w_ready     = 1'b0;
      clint_w_valid  = 1'b0;
      clint_w_data   = '0;
      clint_w_strb   = '0;
      clint_w_last   = 1'b0;
      soc_w_valid    = 1'b0;
      soc_w_data     = '0;
      soc_w_strb     = '0;
      soc_w_last     = 1'b0;
      up_b_valid     = 1'b0;
      up_b_resp      = '0;
      up_b_id        = '0;
      clint_b_ready  = 1'b0;
      soc_b_ready    = 1'b0;
      if (areset_n) begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_hit) begin
`ifdef XBAR_CLINT_WR_ERR_EN
                  up_aw_ready    = 1'b1;
`else
                  clint_aw_valid = up_aw_valid;
                  clint_aw_addr  = up_aw_addr;
                  clint_aw_id    = up_aw_id;
                  clint_aw_len   = up_aw_len;
                  clint_aw_size  = up_aw_size;
                  clint_aw_burst = up_aw_burst;
                  up_aw_ready    = clint_aw_ready;
`endif
               end else begin
                  soc_aw_valid   = up_aw_valid;
                  soc_aw_addr    = up_aw_addr;
                  soc_aw_id      = up_aw_id;
                  soc_aw_len     = up_aw_len;
                  soc_aw_size    = up_aw_size;
                  soc_aw_burst   = up_aw_burst;
                  up_aw_ready    = soc_aw_ready;
               end
               if (up_aw_valid && up_aw_ready) begin
                  wsel_d    = aw_hit;
                  w_state_d = W_DATA;
`ifdef XBAR_CLINT_WR_ERR_EN
                  wid_d     = up_aw_id;
`endif
               end
            end
            W_DATA: begin
               if (wsel_q) begin
`ifdef XBAR_CLINT_WR_ERR_EN
                  up_w_ready    = 1'b1;
`else
                  clint_w_valid = up_w_valid;
                  clint_w_data  = up_w_data;
                  clint_w_strb  = up_w_strb;
                  clint_w_last  = up_w_last;
                  up_w_ready    = clint_w_ready;
`endif
               end else begin
                  soc_w_valid   = up_w_valid;
                  soc_w_data    = up_w_data;
                  soc_w_strb    = up_w_strb;
                  soc_w_last    = up_w_last;
                  up_w_ready    = soc_w_ready;
               end
               if (up_w_valid && up_w_ready && up_w_last) w_state_d = W_RESP;
            end
            W_RESP: begin
               if (wsel_q) begin
`ifdef XBAR_CLINT_WR_ERR_EN
                  up_b_valid    = 1'b1;
                  up_b_resp     = 2'b10;
                  up_b_id       = wid_q;
`else
                  up_b_valid    = clint_b_valid;
                  up_b_resp     = clint_b_resp;
                  up_b_id       = clint_b_id;
                  clint_b_ready = up_b_ready;
`endif
               end else begin
                  up_b_valid    = soc_b_valid;
                  up_b_resp     = soc_b_resp;
                  up_b_id       = soc_b_id;
                  soc_b_ready   = up_b_ready;
               end
               if (up_b_valid && up_b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
         endcase
      end
   end

endmodule
